// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready streaming FIFO with first-word-fall-through output,
// registered occupancy count, programmable almost-full/almost-empty flags and
// a synchronous flush.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset, clears all state
//   flush        synchronous clear, wins over push and pop
//   in_valid     producer offers in_data
//   in_ready     FIFO not full (independent of out_ready)
//   in_data      write data
//   out_valid    FIFO not empty; out_data holds the oldest word
//   out_ready    consumer takes out_data this cycle
//   out_data     oldest stored word (combinational read, no bypass)
//   count        occupancy 0..DEPTH
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
module stream_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NBITS    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]    w_ptr_q, w_ptr_d;
  logic [PW-1:0]    r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;

  // Pointer MSB is a wrap bit: equal low bits with differing wrap bits means full.
  assign full  = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) && (w_ptr_q[AW] != r_ptr_q[AW]);
  assign empty = (w_ptr_q == r_ptr_q);

  assign push = in_valid & ~full;
  assign pop  = out_ready & ~empty;

  assign in_ready     = ~full;
  assign out_valid    = ~empty;
  assign out_data     = mem_q[r_ptr_q[AW-1:0]];
  assign count        = count_q;
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));

  // Next-state for pointers and count; flush overrides any handshake.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (push) w_ptr_d = w_ptr_q + PW'(1);
      if (pop)  r_ptr_d = r_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[w_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (DEPTH=4, NBITS=16) against a queue model.
module tb_stream_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NBITS = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int         AF    = DEPTH - 1;
  localparam int         AE    = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NBITS-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [NBITS-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             almost_full;
  logic             almost_empty;

  logic [NBITS-1:0] model_q [$];
  int checks = 0;
  int errors = 0;

  stream_fifo #(.DEPTH(DEPTH), .NBITS(NBITS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, "/count"}, 32'(count), 32'(n));
    check({tag, "/out_valid"}, 32'(out_valid), 32'(n > 0));
    check({tag, "/in_ready"}, 32'(in_ready), 32'(n < DEPTH));
    check({tag, "/almost_full"}, 32'(almost_full), 32'(n >= AF));
    check({tag, "/almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    if (n > 0) check({tag, "/out_data"}, 32'(out_data), 32'(model_q[0]));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input string tag, input logic iv, input logic [NBITS-1:0] d,
                       input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    #1;
    check_state("reset");
    repeat (2) @(negedge clk);
    check_state("reset_hold");
    rst = 1'b1;

    // Reset and fill
    cycle("fill1", 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle("fill2", 1'b1, 16'h2222, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 16'h3333, 1'b0, 1'b0);
    check("fill3_af", 32'(almost_full), 32'd1);
    cycle("fill4", 1'b1, 16'h4444, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle("fill5", 1'b1, 16'h5555, 1'b0, 1'b0);
    check("fill5_count", 32'(count), 32'd4);

    // Drain in order
    cycle("drain1", 1'b0, '0, 1'b1, 1'b0);
    check("drain1_data", 32'(out_data), 32'h2222);
    cycle("drain2", 1'b0, '0, 1'b1, 1'b0);
    check("drain2_data", 32'(out_data), 32'h3333);
    cycle("drain3", 1'b0, '0, 1'b1, 1'b0);
    check("drain3_data", 32'(out_data), 32'h4444);
    cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
    check("drain4_valid", 32'(out_valid), 32'd0);

    // Streaming with wrap-around
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, NBITS'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 32'd1);
      check("stream_data", 32'(out_data), 32'(i));
    end
    cycle("stream_tail", 1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, NBITS'(16'hA000 + i), 1'b0, 1'b0);
    check("refill_full", 32'(in_ready), 32'd0);
    cycle("full_pp", 1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("full_pp_count", 32'(count), 32'd3);
    check("full_pp_ready", 32'(in_ready), 32'd1);
    check("full_pp_data", 32'(out_data), 32'hA001);

    // Flush at count=3 with push and pop asserted
    cycle("flush", 1'b1, 16'h7777, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_ae", 32'(almost_empty), 32'd1);
    cycle("post_flush", 1'b1, 16'hABCD, 1'b0, 1'b0);
    check("post_flush_data", 32'(out_data), 32'hABCD);

    // Asynchronous reset mid-stream at count=2
    cycle("pre_rst", 1'b1, 16'h1234, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_count", 32'(count), 32'd0);
    model_q.delete();
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    cycle("after_rst", 1'b1, 16'h0F0F, 1'b0, 1'b0);
    check("after_rst_data", 32'(out_data), 32'h0F0F);
    cycle("after_rst_pop", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), NBITS'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
